// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   owner_t    : identifies which requester issued a memory request
//   MEM_ADDR_W : default request address width
//   MEM_DATA_W : default data width (strobe width is MEM_DATA_W/8)
package mem_arb_pkg;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of request owners. One entry is pushed for every request the
// memory accepts and popped for every response the memory delivers, so the
// head always names the requester that owns the next returning response.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears pointers/count)
//   i_push       : write i_push_data at the tail (ignored when full)
//   i_push_data  : owner of the request being accepted
//   i_pop        : retire the head entry (ignored when empty)
//   o_head       : owner at the head (valid only when !o_empty)
//   o_full       : count == DEPTH
//   o_empty      : count == 0
//   o_count      : number of stored entries
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  owner_t           i_push_data,
  input  logic             i_pop,
  output owner_t           o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  owner_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_W'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; stale entries are never observed while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one in-order memory port between the instruction-fetch (i_*) and
// load/store (d_*) requesters. Requests are arbitrated round-robin and passed
// through combinationally; an owner FIFO records who issued each accepted
// request and steers each in-order response back to that requester.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   i_req_* / i_resp_*     : fetch request (read-only) and response channels
//   d_req_* / d_resp_*     : data request (read/write) and response channels
//   mem_req_* / mem_resp_* : shared memory request and response channels
//   outstanding            : requests accepted by memory, not yet answered
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W          = MEM_ADDR_W,
  parameter  int DATA_W          = MEM_DATA_W,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int STRB_W          = DATA_W / 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [STRB_W-1:0] d_req_wstrb,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [CNT_W-1:0]  outstanding
);

  owner_t r_last_grant;
  logic   r_lock;
  owner_t r_lock_owner;

  owner_t w_winner;
  logic   w_win_valid;
  logic   w_full;
  logic   w_empty;
  owner_t w_head;
  logic   w_push;
  logic   w_pop;
  logic   w_head_i;
  logic   w_head_d;

  // Winner depends only on registered state and the requester valids, so
  // mem_req_ready never feeds back into mem_req_valid.
  always_comb begin
    w_winner = (r_last_grant == OWNER_I) ? OWNER_D : OWNER_I;
    if (r_lock)                           w_winner = r_lock_owner;
    else if (i_req_valid && !d_req_valid) w_winner = OWNER_I;
    else if (d_req_valid && !i_req_valid) w_winner = OWNER_D;
  end

  assign w_win_valid   = (w_winner == OWNER_I) ? i_req_valid : d_req_valid;
  assign mem_req_valid = w_win_valid && !w_full;
  assign mem_req_addr  = (w_winner == OWNER_I) ? i_req_addr : d_req_addr;
  assign mem_req_we    = (w_winner == OWNER_D) && d_req_we;
  assign mem_req_wdata = (w_winner == OWNER_D) ? d_req_wdata : '0;
  assign mem_req_wstrb = (w_winner == OWNER_D) ? d_req_wstrb : '0;

  // Ready is also qualified by the winner's own valid so neither requester
  // sees ready while nothing is pending.
  assign i_req_ready = (w_winner == OWNER_I) && i_req_valid && mem_req_ready && !w_full;
  assign d_req_ready = (w_winner == OWNER_D) && d_req_valid && mem_req_ready && !w_full;

  assign w_push = mem_req_valid && mem_req_ready;

  assign w_head_i       = !w_empty && (w_head == OWNER_I);
  assign w_head_d       = !w_empty && (w_head == OWNER_D);
  assign i_resp_valid   = w_head_i && mem_resp_valid;
  assign d_resp_valid   = w_head_d && mem_resp_valid;
  assign i_resp_data    = mem_resp_data;
  assign d_resp_data    = mem_resp_data;
  assign mem_resp_ready = (w_head_i && i_resp_ready) || (w_head_d && d_resp_ready);
  assign w_pop          = mem_resp_valid && mem_resp_ready;

  // A stalled request pins the winner so the memory side sees a stable
  // request until it fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= OWNER_I;
      r_lock       <= 1'b0;
      r_lock_owner <= OWNER_I;
    end else begin
      r_lock       <= mem_req_valid && !mem_req_ready;
      r_lock_owner <= w_winner;
      if (w_push) r_last_grant <= w_winner;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_winner),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (outstanding)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid, i_resp_ready;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_resp_valid, d_resp_ready;
  logic [31:0] d_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (32), .DATA_W (32), .MAX_OUTSTANDING (4)
  ) dut (
    .clk (clk), .reset (reset),
    .i_req_valid (i_req_valid), .i_req_ready (i_req_ready), .i_req_addr (i_req_addr),
    .i_resp_valid (i_resp_valid), .i_resp_ready (i_resp_ready), .i_resp_data (i_resp_data),
    .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_req_addr (d_req_addr),
    .d_req_we (d_req_we), .d_req_wdata (d_req_wdata), .d_req_wstrb (d_req_wstrb),
    .d_resp_valid (d_resp_valid), .d_resp_ready (d_resp_ready), .d_resp_data (d_resp_data),
    .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready), .mem_req_addr (mem_req_addr),
    .mem_req_we (mem_req_we), .mem_req_wdata (mem_req_wdata), .mem_req_wstrb (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid), .mem_resp_ready (mem_resp_ready), .mem_resp_data (mem_resp_data),
    .outstanding (outstanding)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  mreq_t       exp_mreq [$];
  logic [31:0] exp_iresp [$];
  logic [31:0] exp_dresp [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic mreq_t mk(input logic [31:0] a, input logic we,
                               input logic [31:0] wd, input logic [3:0] ws);
    mreq_t r;
    r.addr = a; r.we = we; r.wdata = wd; r.wstrb = ws;
    return r;
  endfunction

  // Monitor: compares every fired transfer against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mreq.size() == 0) check("mreq_unexpected", 1, 0);
        else begin
          mreq_t e;
          e = exp_mreq.pop_front();
          check("mreq_addr", mem_req_addr, e.addr);
          check("mreq_we", mem_req_we, e.we);
          check("mreq_wstrb", mem_req_wstrb, e.wstrb);
          if (e.we) check("mreq_wdata", mem_req_wdata, e.wdata);
        end
      end
      if (i_resp_valid && i_resp_ready) begin
        if (exp_iresp.size() == 0) check("iresp_unexpected", 1, 0);
        else check("iresp_data", i_resp_data, exp_iresp.pop_front());
      end
      if (d_resp_valid && d_resp_ready) begin
        if (exp_dresp.size() == 0) check("dresp_unexpected", 1, 0);
        else check("dresp_data", d_resp_data, exp_dresp.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
    mem_resp_valid = 0; mem_resp_data = '0;
    mem_req_ready = 1; i_resp_ready = 1; d_resp_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic respond(input logic [31:0] data);
    cyc(); mem_resp_valid = 1; mem_resp_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    // Reset state
    settle();
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_resp_ready", mem_resp_ready, 0);
    check("rst_i_resp_valid", i_resp_valid, 0);
    check("rst_d_resp_valid", d_resp_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_i_req_ready", i_req_ready, 0);
    check("rst_d_req_ready", d_req_ready, 0);

    // Single fetch read and its response
    exp_mreq.push_back(mk(32'h100, 0, 0, 4'h0));
    exp_iresp.push_back(32'hDEADBEEF);
    cyc(); i_req_valid = 1; i_req_addr = 32'h100;
    settle();
    check("t1_outstanding0", outstanding, 0);
    check("t1_i_req_ready", i_req_ready, 1);
    cyc(); i_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
    settle();
    check("t1_outstanding1", outstanding, 1);
    check("t1_i_resp_valid", i_resp_valid, 1);
    check("t1_d_resp_valid", d_resp_valid, 0);
    cyc(); mem_resp_valid = 0;
    settle();
    check("t1_outstanding_end", outstanding, 0);

    // Tie from reset: D first, then alternate D,I,D,I
    do_reset();
    exp_mreq.push_back(mk(32'h300, 1, 32'hA5A5A5A5, 4'hF));
    exp_mreq.push_back(mk(32'h200, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'h300, 1, 32'hA5A5A5A5, 4'hF));
    exp_mreq.push_back(mk(32'h200, 0, 0, 4'h0));
    exp_dresp.push_back(32'h1); exp_iresp.push_back(32'h2);
    exp_dresp.push_back(32'h3); exp_iresp.push_back(32'h4);
    cyc();
    i_req_valid = 1; i_req_addr = 32'h200;
    d_req_valid = 1; d_req_addr = 32'h300; d_req_we = 1; d_req_wdata = 32'hA5A5A5A5; d_req_wstrb = 4'hF;
    settle();
    check("t2_first_we_is_d", mem_req_we, 1);
    cyc(); cyc(); cyc();
    cyc(); idle();
    settle();
    check("t2_outstanding4", outstanding, 4);
    respond(32'h1); respond(32'h2); respond(32'h3); respond(32'h4);
    cyc(); mem_resp_valid = 0;
    settle();
    check("t2_outstanding_end", outstanding, 0);

    // Lock: stalled I request holds even when D arrives with priority
    exp_mreq.push_back(mk(32'h400, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'h500, 0, 0, 4'h0));
    exp_iresp.push_back(32'h11); exp_dresp.push_back(32'h22);
    cyc(); i_req_valid = 1; i_req_addr = 32'h400; mem_req_ready = 0;
    settle(); check("t3_addr_c1", mem_req_addr, 32'h400);
    cyc(); d_req_valid = 1; d_req_addr = 32'h500; d_req_we = 0;
    settle(); check("t3_addr_c2", mem_req_addr, 32'h400);
    check("t3_d_ready_c2", d_req_ready, 0);
    cyc();
    settle(); check("t3_addr_c3", mem_req_addr, 32'h400);
    cyc(); mem_req_ready = 1;
    settle(); check("t3_addr_fire", mem_req_addr, 32'h400);
    cyc(); i_req_valid = 0;
    settle(); check("t3_d_next", mem_req_addr, 32'h500);
    cyc(); d_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h11;
    respond(32'h22);
    cyc(); mem_resp_valid = 0;

    // Full: 5th request waits, a same-cycle pop does not admit it
    for (int k = 0; k < 5; k++) exp_mreq.push_back(mk(32'h600, 0, 0, 4'h0));
    for (int k = 1; k <= 5; k++) exp_dresp.push_back(32'h50 + k);
    cyc(); d_req_valid = 1; d_req_addr = 32'h600; d_req_we = 0;
    cyc(); cyc(); cyc();
    cyc(); mem_resp_valid = 1; mem_resp_data = 32'h51;
    settle();
    check("t4_outstanding4", outstanding, 4);
    check("t4_mem_req_valid_full", mem_req_valid, 0);
    check("t4_d_req_ready_full", d_req_ready, 0);
    cyc(); mem_resp_valid = 0;
    settle();
    check("t4_outstanding3", outstanding, 3);
    check("t4_mem_req_valid_after", mem_req_valid, 1);
    cyc(); d_req_valid = 0;
    settle();
    check("t4_outstanding4b", outstanding, 4);
    respond(32'h52); respond(32'h53); respond(32'h54); respond(32'h55);
    cyc(); mem_resp_valid = 0;
    settle();
    check("t4_outstanding_end", outstanding, 0);

    // Interleaved D write, I read, D read with D response backpressure
    exp_mreq.push_back(mk(32'h700, 1, 32'h12345678, 4'b0011));
    exp_mreq.push_back(mk(32'h800, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'h900, 0, 0, 4'h0));
    exp_dresp.push_back(32'hAAAA0001);
    exp_iresp.push_back(32'hBBBB0002);
    exp_dresp.push_back(32'hCCCC0003);
    cyc(); d_req_valid = 1; d_req_addr = 32'h700; d_req_we = 1; d_req_wdata = 32'h12345678; d_req_wstrb = 4'b0011;
    cyc(); d_req_valid = 0; d_req_we = 0; d_req_wstrb = 0; i_req_valid = 1; i_req_addr = 32'h800;
    cyc(); i_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h900;
    cyc(); d_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA0001;
    settle(); check("t5_ack_to_d", d_resp_valid, 1);
    check("t5_ack_not_i", i_resp_valid, 0);
    cyc(); mem_resp_data = 32'hBBBB0002;
    settle(); check("t5_rd_to_i", i_resp_valid, 1);
    check("t5_rd_not_d", d_resp_valid, 0);
    cyc(); mem_resp_data = 32'hCCCC0003; d_resp_ready = 0;
    settle(); check("t5_stall_ready_c1", mem_resp_ready, 0);
    check("t5_stall_dvalid", d_resp_valid, 1);
    check("t5_stall_ivalid", i_resp_valid, 0);
    cyc();
    settle(); check("t5_stall_ready_c2", mem_resp_ready, 0);
    check("t5_stall_outstanding", outstanding, 1);
    cyc(); d_resp_ready = 1;
    settle(); check("t5_release_ready", mem_resp_ready, 1);
    cyc(); mem_resp_valid = 0;
    settle(); check("t5_outstanding_end", outstanding, 0);

    // Reset with 3 outstanding (last grant D before reset)
    exp_mreq.push_back(mk(32'hA00, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'hA00, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'hA40, 0, 0, 4'h0));
    cyc(); i_req_valid = 1; i_req_addr = 32'hA00;
    cyc();
    cyc(); i_req_valid = 0; d_req_valid = 1; d_req_addr = 32'hA40; d_req_we = 0;
    cyc(); d_req_valid = 0;
    settle(); check("t6_outstanding3", outstanding, 3);
    cyc(); reset = 1;
    cyc(); reset = 0; mem_resp_valid = 1; mem_resp_data = 32'hBAD;
    settle();
    check("t6_outstanding0", outstanding, 0);
    check("t6_mem_resp_ready", mem_resp_ready, 0);
    check("t6_i_resp_valid", i_resp_valid, 0);
    check("t6_d_resp_valid", d_resp_valid, 0);
    exp_mreq.push_back(mk(32'hC00, 0, 0, 4'h0));
    exp_mreq.push_back(mk(32'hB00, 0, 0, 4'h0));
    cyc(); mem_resp_valid = 0;
    i_req_valid = 1; i_req_addr = 32'hB00;
    d_req_valid = 1; d_req_addr = 32'hC00; d_req_we = 0;
    settle(); check("t6_tie_to_d", mem_req_addr, 32'hC00);
    cyc(); d_req_valid = 0;
    cyc(); i_req_valid = 0;
    settle(); check("t6_outstanding2", outstanding, 2);

    check("end_mreq_queue_empty", exp_mreq.size(), 0);
    check("end_iresp_queue_empty", exp_iresp.size(), 0);
    check("end_dresp_queue_empty", exp_dresp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
